// File: rtl/rr_mux_sequencer.sv
// rr_mux_sequencer
// Round-robin select sequencer that drives the select lines of a 4-to-1 mux.
// A granted channel is held for HOLD_CYCLES clocks so the mux output stays
// stable for a known window. The last-served channel gets the lowest priority
// in the next arbitration.
//
// Ports:
//   clk    in   system clock, rising-edge
//   rst    in   synchronous reset, active-high
//   en     in   enable; gates only new grants, never shortens a running one
//   r0..r3 in   per-channel requests (channel n drives mux input dn)
//   s1,s0  out  registered mux select, {s1,s0} = granted channel index
//   valid  out  high while {s1,s0} holds a granted channel
//   done   out  one-cycle pulse on the final dwell cycle of a grant
//   busy   out  high in GRANT state (same as valid)
module rr_mux_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic r0,
  input  logic r1,
  input  logic r2,
  input  logic r3,
  output logic s1,
  output logic s0,
  output logic valid,
  output logic done,
  output logic busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state, state_next;
  logic [1:0]       sel, sel_next;
  logic [1:0]       last, last_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             done_next;
  logic [3:0]       req;
  logic             final_cycle;
  logic [1:0]       ptr;
  logic [1:0]       winner;
  logic             found;

  assign req         = {r3, r2, r1, r0};
  assign final_cycle = (state == GRANT) && (cnt == CNT_LAST);

  // In the final dwell cycle the pointer is already the channel being
  // served, so a back-to-back grant sees it as lowest priority.
  assign ptr = final_cycle ? sel : last;

  // Search order ptr+1, ptr+2, ptr+3, ptr (2-bit wrap); first hit wins.
  always_comb begin
    logic [1:0] idx;
    winner = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    sel_next   = sel;
    cnt_next   = cnt;
    last_next  = last;
    case (state)
      IDLE: begin
        if (en && found) begin
          sel_next   = winner;
          cnt_next   = '0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (final_cycle) begin
          last_next = sel;
          cnt_next  = '0;
          if (en && found) begin
            sel_next = winner;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    // done is registered, so it is predicted from the next counter value.
    done_next = (state_next == GRANT) && (cnt_next == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 2'd0;
      cnt   <= '0;
      last  <= 2'd3;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      sel   <= sel_next;
      cnt   <= cnt_next;
      last  <= last_next;
      done  <= done_next;
    end
  end

  assign s1    = sel[1];
  assign s0    = sel[0];
  assign valid = (state == GRANT);
  assign busy  = (state == GRANT);

endmodule

// File: tb/tb_rr_mux_sequencer.sv
// tb_rr_mux_sequencer
// Scoreboard bench: directed stimulus pushes the expected grant order into a
// queue; monitors on the falling edge pop one entry at the start of every
// grant and check the select, its stability, dwell length and done pulse.
// Two instances: HOLD_CYCLES=4 (main) and HOLD_CYCLES=1.
module tb_rr_mux_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic r0 = 1'b0, r1 = 1'b0, r2 = 1'b0, r3 = 1'b0;
  logic s1, s0, valid, done, busy;

  logic en_h1 = 1'b0;
  logic r0_h1 = 1'b0, r3_h1 = 1'b0;
  logic s1_h1, s0_h1, valid_h1, done_h1, busy_h1;

  int checks = 0;
  int failures = 0;

  int exp_q4[$];
  int exp_q1[$];
  int dwell4 = 0;
  int cur4 = 0;
  int cur1 = 0;

  always #5 clk = ~clk;

  rr_mux_sequencer #(.HOLD_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .en(en),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3),
    .s1(s1), .s0(s0), .valid(valid), .done(done), .busy(busy)
  );

  rr_mux_sequencer #(.HOLD_CYCLES(1), .CNT_W(3)) dut_h1 (
    .clk(clk), .rst(rst), .en(en_h1),
    .r0(r0_h1), .r1(1'b0), .r2(1'b0), .r3(r3_h1),
    .s1(s1_h1), .s0(s0_h1), .valid(valid_h1), .done(done_h1), .busy(busy_h1)
  );

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Main instance monitor: 4-cycle dwell model.
  always @(negedge clk) begin
    if (rst) begin
      dwell4 = 0;
    end else if (valid) begin
      if (dwell4 == 0) begin
        if (exp_q4.size() == 0) begin
          check_output("unexpected_grant", exp_q4.size(), 1);
        end else begin
          cur4 = exp_q4.pop_front();
          check_output("grant_chan", {s1, s0}, cur4);
        end
      end else begin
        check_output("sel_stable", {s1, s0}, cur4);
      end
      check_output("done_dwell", done, (dwell4 == 3) ? 1 : 0);
      check_output("busy_grant", busy, 1);
      dwell4 = (dwell4 == 3) ? 0 : dwell4 + 1;
    end else begin
      check_output("done_idle", done, 0);
      check_output("busy_idle", busy, 0);
      dwell4 = 0;
    end
  end

  // HOLD_CYCLES=1 monitor: every grant cycle is a final cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_h1) begin
        if (exp_q1.size() == 0) begin
          check_output("h1_unexpected_grant", exp_q1.size(), 1);
        end else begin
          cur1 = exp_q1.pop_front();
          check_output("h1_grant_chan", {s1_h1, s0_h1}, cur1);
        end
        check_output("h1_done", done_h1, 1);
        check_output("h1_busy", busy_h1, 1);
      end else begin
        check_output("h1_done_idle", done_h1, 0);
      end
    end
  end

  task automatic apply_stimulus();
    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_output("rst_valid", valid, 0);
    check_output("rst_sel", {s1, s0}, 0);
    check_output("rst_done", done, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_h1_valid", valid_h1, 0);

    // 1: enabled, no requests
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_output("t1_valid", valid, 0);
      check_output("t1_done", done, 0);
      check_output("t1_sel", {s1, s0}, 0);
    end

    // 2: all requests held, five rotating grants with no valid gap
    exp_q4.push_back(0);
    exp_q4.push_back(1);
    exp_q4.push_back(2);
    exp_q4.push_back(3);
    exp_q4.push_back(0);
    {r3, r2, r1, r0} = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_output("t2_valid_cont", valid, 1);
    end
    {r3, r2, r1, r0} = 4'b0000;
    tick();
    check_output("t2_valid_end", valid, 0);

    // 3: single-cycle pulse on r2
    exp_q4.push_back(2);
    r2 = 1'b1;
    tick();
    r2 = 1'b0;
    check_output("t3_sel", {s1, s0}, 2);
    check_output("t3_valid", valid, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("t3_valid_hold", valid, 1);
    end
    tick();
    check_output("t3_valid_end", valid, 0);

    // 4: reset in the 2nd dwell cycle of a ch1 grant
    exp_q4.push_back(1);
    r1 = 1'b1;
    tick();
    check_output("t4_sel_pre", {s1, s0}, 1);
    tick();
    rst = 1'b1;
    r1 = 1'b0;
    tick();
    check_output("t4_rst_valid", valid, 0);
    check_output("t4_rst_sel", {s1, s0}, 0);
    check_output("t4_rst_done", done, 0);
    rst = 1'b0;
    exp_q4.push_back(1);
    exp_q4.push_back(3);
    r1 = 1'b1;
    r3 = 1'b1;
    tick();
    check_output("t4_first_after_rst", {s1, s0}, 1);
    for (int i = 0; i < 7; i++) begin
      tick();
      check_output("t4_valid_cont", valid, 1);
    end
    r1 = 1'b0;
    r3 = 1'b0;
    tick();
    check_output("t4_valid_end", valid, 0);

    // 5: en dropped mid-grant, then requests ignored until en returns
    exp_q4.push_back(1);
    r1 = 1'b1;
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("t5_valid_hold", valid, 1);
    end
    tick();
    check_output("t5_idle", valid, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_output("t5_en_low", valid, 0);
    end
    exp_q4.push_back(1);
    en = 1'b1;
    tick();
    check_output("t5_regrant_valid", valid, 1);
    check_output("t5_regrant_sel", {s1, s0}, 1);
    r1 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    tick();
    check_output("t5_valid_end", valid, 0);

    // 6: HOLD_CYCLES=1, r0 and r3 alternate every cycle
    for (int i = 0; i < 3; i++) begin
      exp_q1.push_back(0);
      exp_q1.push_back(3);
    end
    en_h1 = 1'b1;
    r0_h1 = 1'b1;
    r3_h1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_output("t6_valid", valid_h1, 1);
      check_output("t6_done", done_h1, 1);
      check_output("t6_sel", {s1_h1, s0_h1}, (i % 2 == 0) ? 0 : 3);
    end
    r0_h1 = 1'b0;
    r3_h1 = 1'b0;
    tick();
    check_output("t6_valid_end", valid_h1, 0);
    tick();
  endtask

  initial begin
    apply_stimulus();
    check_output("q4_drained", exp_q4.size(), 0);
    check_output("q1_drained", exp_q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
